// File: rtl/data_sram_responder.sv
// data_sram_responder: SRAM-style data-port responder for bring-up simulations.
// Word array with fixed 1-cycle read latency, byte-lane writes (read-before-write),
// and address-window decode. Out-of-window accesses return FILL and pulse sram_err.
// Optional feature: define SRAM_RESP_STATS_EN to build saturating in-window
// read/write counters; otherwise stat_rd_cnt/stat_wr_cnt are tied to zero.
module data_sram_responder #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BASE      = 32'h0000_0000,
  parameter logic [31:0] BASE_MASK = 32'hFFFF_F000,
  parameter logic [31:0] FILL      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        sram_err,
  output logic [31:0] stat_rd_cnt,
  output logic [31:0] stat_wr_cnt
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx_c;
  logic              hit_c;
  logic              rd_c;
  logic              wr_c;
  logic              miss_c;

  // Address decode and access classification
  always_comb begin
    idx_c  = sram_addr[ADDR_W+1:2];
    hit_c  = ((sram_addr & BASE_MASK) == BASE);
    rd_c   = sram_en && hit_c && (sram_wen == 4'b0000);
    wr_c   = sram_en && hit_c && (sram_wen != 4'b0000);
    miss_c = sram_en && !hit_c;
  end

  // Byte-lane array write; suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (!rst && wr_c) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (sram_wen[i]) begin
          mem[idx_c][i*LANE_W +: LANE_W] <= sram_wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Response register: pre-write word on hits, FILL on misses, hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_rdata <= 32'h0;
      sram_err   <= 1'b0;
    end else begin
      sram_err <= miss_c;
      if (sram_en) begin
        sram_rdata <= hit_c ? mem[idx_c] : FILL;
      end
    end
  end

`ifdef SRAM_RESP_STATS_EN
  // Saturating in-window access counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_cnt <= 32'h0;
      stat_wr_cnt <= 32'h0;
    end else begin
      if (rd_c && (stat_rd_cnt != 32'hFFFF_FFFF)) begin
        stat_rd_cnt <= stat_rd_cnt + 32'd1;
      end
      if (wr_c && (stat_wr_cnt != 32'hFFFF_FFFF)) begin
        stat_wr_cnt <= stat_wr_cnt + 32'd1;
      end
    end
  end
`else
  // Counters not built
  assign stat_rd_cnt = 32'h0;
  assign stat_wr_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: directed scenarios plus a randomized
// stream compared against a behavioural word-array model.
module tb_data_sram_responder;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam logic [31:0] BASE_MASK = 32'hFFFF_E000;
  localparam logic [31:0] FILL      = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_err;
  logic [31:0] stat_rd_cnt;
  logic [31:0] stat_wr_cnt;

  data_sram_responder #(
    .ADDR_W(ADDR_W), .BASE(BASE), .BASE_MASK(BASE_MASK), .FILL(FILL)
  ) dut (
    .clk(clk), .rst(rst), .sram_en(sram_en), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_err(sram_err), .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mem_m [DEPTH];
  bit          known_m [DEPTH];
  logic [31:0] exp_rdata;
  bit          exp_known;
  logic        exp_err;
  logic [31:0] rd_cnt_m;
  logic [31:0] wr_cnt_m;

  int n_checks;
  int n_fail;

  function automatic logic [31:0] exp_stat(input logic [31:0] cnt);
`ifdef SRAM_RESP_STATS_EN
    return cnt;
`else
    return 32'h0 & cnt;
`endif
  endfunction

  // Drive one cycle and advance the model; returns just after the capturing edge
  task automatic access(input logic en, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int idx;
    @(negedge clk);
    sram_en = en; sram_wen = wen; sram_addr = addr; sram_wdata = wdata;
    idx = int'((addr >> 2) % DEPTH);
    exp_err = 1'b0;
    if (en) begin
      if ((addr & BASE_MASK) == BASE) begin
        exp_rdata = mem_m[idx];
        exp_known = known_m[idx];
        if (wen == 4'b0000) begin
          if (rd_cnt_m != 32'hFFFF_FFFF) rd_cnt_m = rd_cnt_m + 1;
        end else begin
          for (int b = 0; b < 4; b++)
            if (wen[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
          if (wen != 4'hF && !known_m[idx]) known_m[idx] = 1'b0;
          else known_m[idx] = 1'b1;
          if (wr_cnt_m != 32'hFFFF_FFFF) wr_cnt_m = wr_cnt_m + 1;
        end
      end else begin
        exp_rdata = FILL;
        exp_known = 1'b1;
        exp_err   = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks += 4;
    if (sram_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected %h", sram_rdata, 32'h0); end
    if (sram_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", sram_err); end
    if (stat_rd_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_stat_rd: got %h expected 0", stat_rd_cnt); end
    if (stat_wr_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_stat_wr: got %h expected 0", stat_wr_cnt); end
  endtask

  task automatic preload();
    for (int i = 0; i < 16; i++) access(1'b1, 4'hF, 32'(i << 2), $urandom);
  endtask

  task automatic test_full_write_read();
    access(1'b1, 4'hF, 32'h10, 32'h1234_5678);
    n_checks++;
    if (sram_rdata !== exp_rdata) begin n_fail++; $display("FAIL rbw_old_data: got %h expected %h", sram_rdata, exp_rdata); end
    access(1'b1, 4'h0, 32'h10, 32'h0);
    n_checks++;
    if (sram_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL full_write_read: got %h expected %h", sram_rdata, 32'h1234_5678); end
  endtask

  task automatic test_partial_write();
    access(1'b1, 4'b0101, 32'h10, 32'hAABB_CCDD);
    access(1'b1, 4'h0, 32'h10, 32'h0);
    n_checks++;
    if (sram_rdata !== 32'h12BB_56DD) begin n_fail++; $display("FAIL partial_write: got %h expected %h", sram_rdata, 32'h12BB_56DD); end
  endtask

  task automatic test_miss();
    logic [31:0] rd0, wr0;
    rd0 = stat_rd_cnt; wr0 = stat_wr_cnt;
    access(1'b1, 4'h0, 32'h0000_2000, 32'h0);
    n_checks += 4;
    if (sram_rdata !== FILL) begin n_fail++; $display("FAIL miss_rdata: got %h expected %h", sram_rdata, FILL); end
    if (sram_err !== 1'b1) begin n_fail++; $display("FAIL miss_err: got %b expected 1", sram_err); end
    if (stat_rd_cnt !== rd0) begin n_fail++; $display("FAIL miss_stat_rd: got %h expected %h", stat_rd_cnt, rd0); end
    if (stat_wr_cnt !== wr0) begin n_fail++; $display("FAIL miss_stat_wr: got %h expected %h", stat_wr_cnt, wr0); end
    access(1'b1, 4'hF, 32'h0000_2010, 32'hFFFF_FFFF);
    n_checks++;
    if (sram_err !== 1'b1) begin n_fail++; $display("FAIL miss_write_err: got %b expected 1", sram_err); end
    access(1'b0, 4'hF, 32'h10, 32'h0);
    n_checks += 2;
    if (sram_err !== 1'b0) begin n_fail++; $display("FAIL idle_err: got %b expected 0", sram_err); end
    if (sram_rdata !== FILL) begin n_fail++; $display("FAIL idle_hold_fill: got %h expected %h", sram_rdata, FILL); end
    access(1'b1, 4'h0, 32'h10, 32'h0);
    n_checks++;
    if (sram_rdata !== 32'h12BB_56DD) begin n_fail++; $display("FAIL miss_no_write: got %h expected %h", sram_rdata, 32'h12BB_56DD); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    d = $urandom;
    access(1'b1, 4'hF, 32'h20, d);
    access(1'b1, 4'h0, 32'h20, 32'h0);
    n_checks++;
    if (sram_rdata !== d) begin n_fail++; $display("FAIL b2b_read: got %h expected %h", sram_rdata, d); end
    access(1'b0, 4'h0, 32'h0, 32'h0);
    access(1'b0, 4'hF, 32'h20, ~d);
    n_checks++;
    if (sram_rdata !== d) begin n_fail++; $display("FAIL idle_hold: got %h expected %h", sram_rdata, d); end
    access(1'b1, 4'h0, 32'h1000, 32'h0);
    n_checks += 3;
    if (sram_rdata !== mem_m[0]) begin n_fail++; $display("FAIL wrap_read: got %h expected %h", sram_rdata, mem_m[0]); end
    if (stat_rd_cnt !== exp_stat(rd_cnt_m)) begin n_fail++; $display("FAIL b2b_stat_rd: got %h expected %h", stat_rd_cnt, exp_stat(rd_cnt_m)); end
    if (stat_wr_cnt !== exp_stat(wr_cnt_m)) begin n_fail++; $display("FAIL b2b_stat_wr: got %h expected %h", stat_wr_cnt, exp_stat(wr_cnt_m)); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [3:0]  w;
    int r, kind;
    for (int n = 0; n < 400; n++) begin
      r    = $urandom_range(0, 15);
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = 32'h0000_2000 | 32'(r << 2) | 32'($urandom_range(0, 3));
      else if (kind == 1) a = 32'h0000_1000 | 32'(r << 2);
      else                a = 32'(r << 2) | 32'($urandom_range(0, 3));
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      access($urandom_range(0, 3) != 0, w, a, $urandom);
      n_checks += 3;
      if (exp_known) begin
        n_checks++;
        if (sram_rdata !== exp_rdata) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %h expected %h", n, sram_rdata, exp_rdata); end
      end
      if (sram_err !== exp_err) begin n_fail++; $display("FAIL rand_err[%0d]: got %b expected %b", n, sram_err, exp_err); end
      if (stat_rd_cnt !== exp_stat(rd_cnt_m)) begin n_fail++; $display("FAIL rand_stat_rd[%0d]: got %h expected %h", n, stat_rd_cnt, exp_stat(rd_cnt_m)); end
      if (stat_wr_cnt !== exp_stat(wr_cnt_m)) begin n_fail++; $display("FAIL rand_stat_wr[%0d]: got %h expected %h", n, stat_wr_cnt, exp_stat(wr_cnt_m)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] keep;
    keep = mem_m[4];
    access(1'b1, 4'h0, 32'h04, 32'h0);
    access(1'b1, 4'h0, 32'h2000, 32'h0);
    sram_addr = 32'h08;
    sram_wen  = 4'h0;
    #2 rst = 1'b1;
    #1;
    n_checks += 4;
    if (sram_rdata !== 32'h0) begin n_fail++; $display("FAIL async_rst_rdata: got %h expected 0", sram_rdata); end
    if (sram_err !== 1'b0) begin n_fail++; $display("FAIL async_rst_err: got %b expected 0", sram_err); end
    if (stat_rd_cnt !== 32'h0) begin n_fail++; $display("FAIL async_rst_stat_rd: got %h expected 0", stat_rd_cnt); end
    if (stat_wr_cnt !== 32'h0) begin n_fail++; $display("FAIL async_rst_stat_wr: got %h expected 0", stat_wr_cnt); end
    @(posedge clk); #1;
    n_checks++;
    if (sram_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_discard: got %h expected 0", sram_rdata); end
    @(negedge clk);
    sram_en = 1'b0;
    rst = 1'b0;
    rd_cnt_m = 0; wr_cnt_m = 0;
    access(1'b1, 4'h0, 32'h10, 32'h0);
    n_checks += 3;
    if (sram_rdata !== keep) begin n_fail++; $display("FAIL post_rst_data: got %h expected %h", sram_rdata, keep); end
    if (stat_rd_cnt !== exp_stat(32'd1)) begin n_fail++; $display("FAIL post_rst_stat_rd: got %h expected %h", stat_rd_cnt, exp_stat(32'd1)); end
    if (stat_wr_cnt !== 32'h0) begin n_fail++; $display("FAIL post_rst_stat_wr: got %h expected 0", stat_wr_cnt); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rd_cnt_m = 0; wr_cnt_m = 0;
    exp_rdata = 32'h0; exp_known = 1'b1; exp_err = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin mem_m[i] = 32'h0; known_m[i] = 1'b0; end
    rst = 1'b1;
    sram_en = 1'b0; sram_wen = 4'h0; sram_addr = 32'h0; sram_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    preload();
    test_full_write_read();
    test_partial_write();
    test_miss();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
